// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel types and constants used by the memory fill engine
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  parameter tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'h0,
    instr_type: 4'b1010,
    cmd_intg:   7'h0,
    data_intg:  7'h0
  };

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/rvlab_tlul_memfill_if.sv
// rtl/rvlab_tlul_memfill_if.sv - TL-UL host/device channel bundle for the fill engine
interface rvlab_tlul_memfill_if;
  tlul_pkg::tl_h2d_t tl_o;
  tlul_pkg::tl_d2h_t tl_i;

  modport master (output tl_o, input tl_i);
  modport slave (input tl_o, output tl_i);
endinterface

// File: rtl/rvlab_tlul_memfill.sv
// rtl/rvlab_tlul_memfill.sv - TL-UL memory fill / check engine, one transaction outstanding
module rvlab_tlul_memfill #(
  parameter logic [7:0] SourceId = 8'h00
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        mode_i,
  input  logic [31:0]                 base_addr_i,
  input  logic [15:0]                 word_count_i,
  input  logic [31:0]                 pattern_i,
  input  logic                        incr_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [15:0]                 mismatch_cnt_o,
  rvlab_tlul_memfill_if.master        tl
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    FIN  = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] idx_q;
  logic        cfg_mode_q;
  logic        cfg_incr_q;
  logic [15:0] cfg_count_q;
  // addr_q and word_q track word idx_q: current address and pattern + (incr ? idx : 0)
  logic [31:0] addr_q;
  logic [31:0] word_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] mm_q;
  logic        a_valid_q;
  logic        d_ready_q;

  tlul_pkg::tl_h2d_t h2d;

  // Control FSM; every output is registered and advanced together with the state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= 16'h0;
      cfg_mode_q  <= 1'b0;
      cfg_incr_q  <= 1'b0;
      cfg_count_q <= 16'h0;
      addr_q      <= 32'h0;
      word_q      <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mm_q        <= 16'h0;
      a_valid_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cfg_mode_q  <= mode_i;
            cfg_incr_q  <= incr_i;
            cfg_count_q <= word_count_i;
            addr_q      <= {base_addr_i[31:2], 2'b00};
            word_q      <= pattern_i;
            idx_q       <= 16'h0;
            err_q       <= 1'b0;
            mm_q        <= 16'h0;
            busy_q      <= 1'b1;
            if (word_count_i == 16'h0) begin
              state_q <= FIN;
            end else begin
              state_q   <= REQ;
              a_valid_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (tl.tl_i.a_ready) begin
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            state_q   <= RSP;
          end
        end
        RSP: begin
          if (tl.tl_i.d_valid) begin
            d_ready_q <= 1'b0;
            if (tl.tl_i.d_error) begin
              err_q   <= 1'b1;
              state_q <= FIN;
            end else begin
              if (cfg_mode_q && (tl.tl_i.d_data != word_q) && (mm_q != 16'hFFFF)) begin
                mm_q <= mm_q + 16'h1;
              end
              if (idx_q == cfg_count_q - 16'h1) begin
                state_q <= FIN;
              end else begin
                idx_q     <= idx_q + 16'h1;
                addr_q    <= addr_q + 32'h4;
                word_q    <= word_q + {31'h0, cfg_incr_q};
                a_valid_q <= 1'b1;
                state_q   <= REQ;
              end
            end
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request channel assembly from the registered state
  always_comb begin
    h2d           = '0;
    h2d.a_valid   = a_valid_q;
    h2d.a_opcode  = cfg_mode_q ? tlul_pkg::Get : tlul_pkg::PutFullData;
    h2d.a_param   = 3'h0;
    h2d.a_size    = 2'd2;
    h2d.a_source  = SourceId;
    h2d.a_address = addr_q;
    h2d.a_mask    = 4'hF;
    h2d.a_data    = cfg_mode_q ? 32'h0 : word_q;
    h2d.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
    h2d.d_ready   = d_ready_q;
  end

  assign tl.tl_o = h2d;

  // Response fields the engine has no use for
  logic unused_d2h;
  assign unused_d2h = ^{tl.tl_i.d_opcode, tl.tl_i.d_param, tl.tl_i.d_size,
                        tl.tl_i.d_source, tl.tl_i.d_sink, tl.tl_i.d_user};

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign mismatch_cnt_o = mm_q;

endmodule

// File: doc/rvlab_tlul_memfill.md
RVLAB_TLUL_MEMFILL -- requirements
Module: rvlab_tlul_memfill

Interface
REQ-001 The module SHALL have parameter SourceId, default 8'h00, giving the TL-UL a_source value on every request.
REQ-002 clk_i  input  1  system clock; all logic on the rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 start_i  input  1  single-cycle start pulse; accepted only in IDLE.
REQ-005 mode_i  input  1  operation select: 0 = fill (PutFullData), 1 = check (Get and compare).
REQ-006 base_addr_i  input  32  start byte address; bits [1:0] are ignored and treated as 0.
REQ-007 word_count_i  input  16  number of 32-bit words to process.
REQ-008 pattern_i  input  32  data seed.
REQ-009 incr_i  input  1  1 = expected or written word i is pattern+i; 0 = pattern for every word.
REQ-010 busy_o  output  1  high from the accepted start until done_o.
REQ-011 done_o  output  1  one-cycle completion pulse.
REQ-012 err_o  output  1  sticky bus-error flag; cleared by the next accepted start.
REQ-013 mismatch_cnt_o  output  16  check-mode mismatch count, saturating.
REQ-014 tl_o  output  tlul_pkg::tl_h2d_t  TL-UL host request channel, which also carries d_ready.
REQ-015 tl_i  input  tlul_pkg::tl_d2h_t  TL-UL device response channel, which also carries a_ready.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, RSP and FIN.
REQ-017 In IDLE, a start_i pulse SHALL latch mode, base address (with [1:0] = 0), word count, pattern and incr.
  - Those latched values SHALL be used for the whole operation; later changes to the inputs have no effect.
REQ-018 On the accepted start, err_o and mismatch_cnt_o SHALL be cleared, busy_o SHALL be set, and the word index i SHALL be reset to 0.
REQ-019 After a start with word_count_i = 0, the FSM SHALL go IDLE -> FIN.
  - No TL-UL transaction is issued.
  - done_o pulses on the following cycle.
REQ-020 After a start with word_count_i != 0, the FSM SHALL go IDLE -> REQ.
  - a_valid is asserted the cycle after start (one cycle of start-to-request latency).
REQ-021 In REQ, a_valid SHALL be 1 and all a_* fields SHALL be held stable until the cycle with a_valid && a_ready; the FSM then goes to RSP.
REQ-022 Request fields for word i SHALL be:
  - a_address = base + 4*i, modulo 2^32 (the address wraps around).
  - a_size = 2; a_mask = 4'hF; a_param = 0; a_source = SourceId.
  - a_user = the package default.
REQ-023 In fill mode, requests SHALL use a_opcode = PutFullData and a_data = pattern + (incr ? i : 0), modulo 2^32.
REQ-024 In check mode, requests SHALL use a_opcode = Get and a_data = 0.
REQ-025 Only one transaction SHALL be outstanding at a time; a_valid is 0 in every state other than REQ.
REQ-026 d_ready SHALL be 1 in RSP and 0 in all other states; any d_valid outside RSP is ignored.
REQ-027 In RSP, on d_valid with d_error = 1:
  - err_o is set.
  - The operation aborts and the FSM goes to FIN.
  - No further requests are issued.
REQ-028 In RSP, on d_valid with d_error = 0 in check mode, if d_data differs from the expected word, mismatch_cnt_o SHALL increment.
  - The count saturates at 16'hFFFF.
REQ-029 In RSP, after a d_valid with d_error = 0:
  - If i = count-1, the FSM goes to FIN.
  - Otherwise i increments and the FSM returns to REQ, so there is at least one idle cycle between consecutive requests.
REQ-030 In FIN, done_o SHALL be 1 for exactly one cycle, busy_o SHALL be cleared in the same cycle, and the FSM SHALL go to IDLE.
REQ-031 A start_i pulse outside IDLE SHALL be ignored.
REQ-032 A start_i pulse in the same cycle as FIN SHALL be ignored.
REQ-033 Operation results SHALL remain readable after completion.
  - mismatch_cnt_o and err_o hold until the next accepted start.

Reset
REQ-034 While rst_ni = 0, the module SHALL be in the following state:
  - FSM = IDLE and i = 0.
  - busy_o = 0, done_o = 0, err_o = 0, mismatch_cnt_o = 0.
  - a_valid = 0 and d_ready = 0.
  - All latched configuration = 0.
REQ-035 A reset asserted mid-transaction SHALL abandon the operation immediately without completing the handshake.
  - After release, the block is IDLE and issues no request until a new start.

Verification
REQ-036 Fill: base = 0x1000_0002, count = 3, pattern = 0xA5A5_0000, incr = 1 -> three PutFullData requests:
  - 0x1000_0000 with 0xA5A5_0000; 0x1000_0004 with 0xA5A5_0001; 0x1000_0008 with 0xA5A5_0002.
  - One done_o pulse; err_o = 0.
REQ-037 Check: count = 4, pattern = 0xDEAD_BEEF, incr = 0; the responder returns words 2 and 3 as 0 -> four Get requests, mismatch_cnt_o = 2, done_o pulses once.
REQ-038 Backpressure: hold a_ready = 0 for 5 cycles and delay d_valid by 7 cycles -> all a_* fields stay stable while stalled, and the result matches the no-stall run.
REQ-039 Error: d_error = 1 on word 1 of 4 -> err_o = 1, exactly 2 requests issued, done_o pulses; the next start clears err_o.
REQ-040 Edge cases:
  - count = 0 -> no a_valid, done_o two cycles after start.
  - base = 0xFFFF_FFFC, count = 2 -> second address is 0x0000_0000.
  - A start pulse while busy has no effect.
REQ-041 Reset mid-RSP -> all outputs return to the reset values of REQ-034; a new fill then completes normally.
